// File: rtl/lcd_access_arbiter.sv
// Round-robin arbiter granting three requesters access to a single LCD command
// executor, with a per-phase watchdog that aborts a stuck executor handshake.
module lcd_access_arbiter #(
    parameter logic [3:0]  NOP_OP     = 4'd15,
    parameter logic [15:0] TMO_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [11:0] req_op,
    input  logic [23:0] req_data,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    input  logic        exe_rdy,
    output logic [3:0]  exe_op,
    output logic [7:0]  exe_data,
    output logic        busy,
    output logic [1:0]  owner,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, EXEC, DONE} state_t;

    state_t      state_reg;
    logic [1:0]  rr_ptr_reg;
    logic [15:0] cnt_reg;

    logic [1:0]  cand_idx [3];
    logic [3:0]  op_arr   [3];
    logic [7:0]  data_arr [3];
    logic [1:0]  win_idx;
    logic        win_vld;
    logic        tmo_hit;

    // cand_idx[k] is the requester examined k-th, counting up from rr_ptr mod 3
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_req
            logic [2:0] sum;
            assign sum          = {1'b0, rr_ptr_reg} + 3'(gi);
            assign cand_idx[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            assign op_arr[gi]   = req_op[gi*4 +: 4];
            assign data_arr[gi] = req_data[gi*8 +: 8];
        end
    endgenerate

    // Scan from the lowest priority upward so the highest-priority hit wins
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                win_vld = 1'b1;
                win_idx = cand_idx[k];
            end
        end
    end

    assign tmo_hit = (cnt_reg == TMO_CYCLES - 16'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= 2'd0;
            cnt_reg     <= 16'd0;
            gnt         <= 3'b000;
            done        <= 3'b000;
            exe_op      <= NOP_OP;
            exe_data    <= 8'h00;
            busy        <= 1'b0;
            owner       <= 2'd0;
            timeout_err <= 1'b0;
        end else begin
            gnt  <= 3'b000;
            done <= 3'b000;
            case (state_reg)
                IDLE: begin
                    if (exe_rdy && win_vld) begin
                        owner   <= win_idx;
                        gnt     <= 3'b001 << win_idx;
                        busy    <= 1'b1;
                        cnt_reg <= 16'd0;
                        // A NOP request needs no executor handshake
                        if (op_arr[win_idx] == NOP_OP) begin
                            exe_op    <= NOP_OP;
                            state_reg <= DONE;
                        end else begin
                            exe_op    <= op_arr[win_idx];
                            exe_data  <= data_arr[win_idx];
                            state_reg <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!exe_rdy) begin
                        exe_op    <= NOP_OP;
                        cnt_reg   <= 16'd0;
                        state_reg <= EXEC;
                    end else if (tmo_hit) begin
                        exe_op      <= NOP_OP;
                        timeout_err <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                EXEC: begin
                    if (exe_rdy) begin
                        state_reg <= DONE;
                    end else if (tmo_hit) begin
                        exe_op      <= NOP_OP;
                        timeout_err <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                DONE: begin
                    done       <= 3'b001 << owner;
                    rr_ptr_reg <= (owner == 2'd2) ? 2'd0 : owner + 2'd1;
                    busy       <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
